// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input and output handshakes.
// Single-cycle ops complete on the accept edge. MUL runs an iterative
// shift-add loop for WIDTH cycles. Results and flags are held in HOLD
// until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t                  state;
  logic [2*WIDTH-1:0]      mcand;
  logic [2*WIDTH-1:0]      product;
  logic [2*WIDTH-1:0]      prod_next;
  logic [WIDTH-1:0]        mplier;
  logic [SHW-1:0]          count;

  logic                    accept;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sra_s;
  logic [SHW-1:0]          amt;
  logic                    amt_big;
  logic [WIDTH:0]          sum_ext;
  logic [WIDTH:0]          diff_ext;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_carry;
  logic                    alu_ovf;

  assign a_s      = a;
  assign b_s      = b;
  assign amt      = b[SHW-1:0];
  // Only reachable when WIDTH is not a power of two.
  assign amt_big  = ({1'b0, amt} >= (SHW+1)'(WIDTH));
  assign sra_s    = a_s >>> amt;
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Handshake readiness: free in IDLE, busy in MUL, pass-through of out_ready in HOLD.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      MUL:     in_ready = 1'b0;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Single-cycle ALU result and flags for the op currently on the inputs.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_res = amt_big ? '0 : (a << amt);
      OP_SRL:  alu_res = amt_big ? '0 : (a >> amt);
      OP_SRA:  alu_res = amt_big ? {WIDTH{a[WIDTH-1]}} : sra_s;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // Next partial product of the shift-add multiplier.
  assign prod_next = product + (mplier[0] ? mcand : '0);

  // Control FSM with registered results, flags and multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand     <= {{WIDTH{1'b0}}, a};
              mplier    <= b;
              product   <= '0;
              count     <= '0;
              out_valid <= 1'b0;
              state     <= MUL;
            end else begin
              result    <= alu_res;
              carry     <= alu_carry;
              overflow  <= alu_ovf;
              zero      <= (alu_res == '0);
              negative  <= alu_res[WIDTH-1];
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MUL: begin
          product <= prod_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          count   <= count + 1'b1;
          if (count == SHW'(WIDTH-1)) begin
            result    <= prod_next[WIDTH-1:0];
            carry     <= |prod_next[2*WIDTH-1:WIDTH];
            overflow  <= 1'b0;
            zero      <= (prod_next[WIDTH-1:0] == '0);
            negative  <= prod_next[WIDTH-1];
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, hand-written handshake/reset sequences
// and randomized ops against a plain-arithmetic reference model.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       overflow;
  logic       negative;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    logic       n;
    int         busy;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one op, waits for acceptance, then for out_valid.
  // busy = cycles sampled with out_valid low after acceptance;
  // rdy_hi = how many of those samples had in_ready high.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int busy, output int rdy_hi);
    int guard;
    op = o; a = x; b = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy = 0;
    rdy_hi = 0;
    while (!out_valid && busy < 100) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1; busy++;
    end
    if (!out_valid) chk("result_timeout", 0, 1);
  endtask

  // Reference model: plain integer arithmetic on 8-bit operands.
  function automatic void model(input int o, input int x, input int y,
                                output int r, output int c, output int v);
    int sa, sb, sv, amt, p;
    sa  = (x >= 128) ? x - 256 : x;
    sb  = (y >= 128) ? y - 256 : y;
    amt = y % 8;
    r = 0; c = 0; v = 0;
    case (o)
      0:  r = x & y;
      1:  r = x | y;
      2:  begin r = (x + y) % 256; c = (x + y > 255); sv = sa + sb; v = (sv > 127 || sv < -128); end
      3:  r = (x * (1 << amt)) % 256;
      4:  r = x ^ y;
      5:  r = x / (1 << amt);
      6:  begin r = (x - y + 256) % 256; c = (x < y); sv = sa - sb; v = (sv > 127 || sv < -128); end
      7:  r = (sa >>> amt) & 255;
      8:  r = (sa < sb) ? 1 : 0;
      9:  r = (x < y) ? 1 : 0;
      10: begin p = x * y; r = p % 256; c = (p > 255); end
      default: r = 0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, rdy_hi;
    int er, ec, ev;
    logic [7:0] r0;
    logic [3:0] f0;

    vecs[0]  = '{4'h2, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{4'h6, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[2]  = '{4'h6, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[3]  = '{4'hA, 8'd15,  8'd17,  8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    vecs[4]  = '{4'hA, 8'd16,  8'd16,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8};
    vecs[5]  = '{4'h7, 8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[6]  = '{4'h5, 8'h90, 8'h03, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{4'h3, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[8]  = '{4'hF, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[9]  = '{4'h0, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[10] = '{4'h1, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[11] = '{4'h4, 8'hCC, 8'hAA, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[12] = '{4'h8, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[13] = '{4'h9, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[14] = '{4'h2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[15] = '{4'hB, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[16] = '{4'h3, 8'h01, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'h0; a = 8'h00; b = 8'h00;
    #12;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_flags", int'({carry, zero, overflow, negative}), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, busy, rdy_hi);
      chk($sformatf("vec%0d_result", i), int'(result), int'(vecs[i].res));
      chk($sformatf("vec%0d_carry", i), int'(carry), int'(vecs[i].c));
      chk($sformatf("vec%0d_zero", i), int'(zero), int'(vecs[i].z));
      chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(vecs[i].v));
      chk($sformatf("vec%0d_negative", i), int'(negative), int'(vecs[i].n));
      chk($sformatf("vec%0d_busy_cycles", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_in_ready_while_busy", i), rdy_hi, 0);
    end

    // Backpressure: result must stay put and in_ready must follow out_ready
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'h8, 8'h80, 8'h01, busy, rdy_hi);
    chk("bp_first_result", int'(result), 1);
    r0 = result;
    f0 = {carry, zero, overflow, negative};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_stable_result_%0d", k), int'(result), int'(r0));
      chk($sformatf("bp_stable_flags_%0d", k), int'({carry, zero, overflow, negative}), int'(f0));
      chk($sformatf("bp_out_valid_%0d", k), int'(out_valid), 1);
      chk($sformatf("bp_in_ready_%0d", k), int'(in_ready), 0);
    end
    op = 4'h8; a = 8'hFF; b = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b2b_out_valid", int'(out_valid), 1);
    chk("bp_b2b_result", int'(result), 1);
    send(4'h9, 8'hFF, 8'h01, busy, rdy_hi);
    chk("bp_sltu_result", int'(result), 0);
    chk("bp_sltu_zero", int'(zero), 1);

    // in_valid held during MUL must not be consumed until HOLD
    op = 4'hA; a = 8'd3; b = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'h2; a = 8'd1; b = 8'd1;
    busy = 0;
    while (!out_valid && busy < 100) begin
      @(posedge clk); #1; busy++;
    end
    chk("mulhold_busy", busy, 8);
    chk("mulhold_result", int'(result), 15);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mulhold_next_out_valid", int'(out_valid), 1);
    chk("mulhold_next_result", int'(result), 2);

    // Reset in the 3rd cycle of a MUL aborts it
    send(4'h2, 8'hF0, 8'h20, busy, rdy_hi);
    chk("prereset_result", int'(result), 8'h10);
    op = 4'hA; a = 8'd3; b = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_flags", int'({carry, zero, overflow, negative}), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'h2, 8'd1, 8'd1, busy, rdy_hi);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_result", int'(result), 2);

    // Randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [3:0] ro;
      logic [7:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(ro, ra, rb, busy, rdy_hi);
      model(int'(ro), int'(ra), int'(rb), er, ec, ev);
      chk($sformatf("rnd%0d_op%0h_result", i, ro), int'(result), er);
      chk($sformatf("rnd%0d_op%0h_carry", i, ro), int'(carry), ec);
      chk($sformatf("rnd%0d_op%0h_overflow", i, ro), int'(overflow), ev);
      chk($sformatf("rnd%0d_op%0h_zero", i, ro), int'(zero), (er == 0) ? 1 : 0);
      chk($sformatf("rnd%0d_op%0h_negative", i, ro), int'(negative), (er >= 128) ? 1 : 0);
      chk($sformatf("rnd%0d_op%0h_busy", i, ro), busy, (ro == 4'hA) ? 8 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 6-bit combinational ALU. Operands and opcode enter through a valid/ready handshake. Results and flags leave through a registered valid/ready output stage with backpressure. It adds SLTU, an iterative shift-add multiply, and overflow and negative flags. It sits between the pin-mapping wrapper and the operand/control decode, so the wrapper can drive it from any pin split.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4..32.
SHW, $clog2(WIDTH), derived localparam, shift-amount width; not overridable.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept; combinational from state and out_ready
op  input  4  opcode
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carry  output  1  registered carry/borrow flag
zero  output  1  registered zero flag
overflow  output  1  registered signed-overflow flag
negative  output  1  registered result MSB

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-low, on rst_n.
- Reset state:
  - state=IDLE; out_valid=0; result=0; carry=0; zero=0; overflow=0; negative=0.
  - Multiply datapath registers are 0.
  - in_ready=1 while in IDLE.
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000 (signed), SLTU 1001, MUL 1010 (low WIDTH bits of a*b, unsigned).
  - Any other code gives result=0 and zero=1, with no other flags.
- Shifts:
  - Shift amount is b[SHW-1:0].
  - An amount >= WIDTH gives 0 for SLL/SRL and all-sign for SRA.
- Flags:
  - carry: ADD = bit WIDTH of {0,a}+{0,b}; SUB = bit WIDTH of {0,a}-{0,b} (borrow, 1 when a<b unsigned); MUL = 1 if any of the upper WIDTH product bits is nonzero; all other ops = 0.
  - overflow: signed overflow for ADD/SUB only; 0 otherwise.
  - zero = (result==0).
  - negative = result[WIDTH-1].
- States: IDLE, MUL, HOLD.
- in_ready by state:
  - IDLE: 1.
  - MUL: 0.
  - HOLD: equals out_ready, which allows back-to-back accept.
- Accept: a transfer occurs on an edge with in_valid & in_ready. The op, a and b are sampled on that edge.
- Non-MUL op accepted at edge E: result and flags are written at E and state goes to HOLD, so out_valid=1 in the cycle after E (latency 1).
- MUL accepted at edge E:
  - At E, load the multiplicand, the multiplier and product=0; set count=0; go to MUL.
  - Each MUL edge: conditional add, shift, count+1.
  - The edge with count==WIDTH-1, which is E+WIDTH, writes result and flags and goes to HOLD.
- HOLD:
  - result and flags stay stable while out_ready=0.
  - On out_ready=1 with in_valid=1: the new op is accepted on the same edge and handled as from IDLE.
  - On out_ready=1 with in_valid=0: go to IDLE with out_valid=0. result and flags keep their last values.
- out_valid is 1 only in HOLD.
- in_valid asserted during MUL is ignored and not consumed; the source must hold it.
- rst_n low during MUL or HOLD aborts immediately: the pending result is discarded and all outputs return to their reset values.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20, out_ready=1 -> next cycle out_valid=1, result=0x10, carry=1, overflow=0, zero=0, negative=0.
- SUB a=0x80 b=0x01 -> result=0x7F, carry=0, overflow=1, negative=0. Then SUB a=0x01 b=0x02 -> result=0xFF, carry=1, negative=1.
- MUL a=15 b=17 -> in_ready=0 for 8 cycles, then out_valid=1, result=0xFF, carry=0. Then MUL a=16 b=16 -> result=0x00, carry=1, zero=1.
- SRA a=0x90 b=3 -> 0xF2; SRL a=0x90 b=3 -> 0x12; SLL a=0x01 b=7 -> 0x80; op=1111 -> result=0, zero=1.
- Backpressure: after SLT, hold out_ready=0 for 5 cycles -> result and flags stable, in_ready=0. Then out_ready=1 with in_valid=1 and SLT a=0xFF b=0x01 -> accepted on the same edge; next cycle result=0x01. Then SLTU with the same operands -> result=0x00, zero=1.
- Pull rst_n low in the 3rd cycle of MUL a=3 b=5 -> out_valid=0, result=0, in_ready=1 immediately. After release, a new ADD a=1 b=1 gives result=0x02 with latency 1.
